// File: rtl/cache_top.sv
// cache_top: self-contained CPU request generator, direct-mapped write-back
// write-allocate cache (4 lines x 4 words) and word-addressed main memory.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   COMPARE   | look up current request; complete on hit, else pick miss path
//   WRITEBACK | flush all 4 words of the dirty victim line to memory
//   ALLOCATE  | fill the indexed line with the requested block from memory
//   DONE      | all requests completed; everything holds
//
// Byte address layout (10 bits): [9:6] tag, [5:4] index, [3:2] word, [1:0]
// byte offset. The request table stores word addresses (byte address >> 2)
// since the byte offset is never used.
module cache_top #(
  parameter int NUM_REQ   = 8,
  parameter int MEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] read_data_cache,
  output logic        hit_miss,
  output logic        read_write_cache,
  output logic [3:0]  request_num
);

  localparam int MEM_AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] mem       [MEM_WORDS];
  logic [31:0] line_data [4][4];
  logic [3:0]  line_tag  [4];
  logic [3:0]  valid;
  logic [3:0]  dirty;
  logic        miss_flag;

  logic        req_we;
  logic [7:0]  req_waddr;
  logic [31:0] req_wdata;
  logic [3:0]  req_tag;
  logic [1:0]  req_idx;
  logic [1:0]  req_word;
  logic        line_hit;
  logic        victim_dirty;

  // Fixed request table indexed by the number of completed requests
  always_comb begin
    req_we    = 1'b0;
    req_waddr = 8'h00;
    req_wdata = 32'h0;
    case (request_num)
      4'd0: req_waddr = 8'h00;                 // R 0x000
      4'd1: req_waddr = 8'h01;                 // R 0x004
      4'd2: begin                              // W 0x008
        req_we    = 1'b1;
        req_waddr = 8'h02;
        req_wdata = 32'hDEADBEEF;
      end
      4'd3: req_waddr = 8'h02;                 // R 0x008
      4'd4: req_waddr = 8'h10;                 // R 0x040
      4'd5: req_waddr = 8'h02;                 // R 0x008
      4'd6: begin                              // W 0x014
        req_we    = 1'b1;
        req_waddr = 8'h05;
        req_wdata = 32'h12345678;
      end
      4'd7: req_waddr = 8'h05;                 // R 0x014
      default: req_waddr = 8'h00;
    endcase
  end

  // Address split and tag lookup for the current request
  always_comb begin
    req_tag      = req_waddr[7:4];
    req_idx      = req_waddr[3:2];
    req_word     = req_waddr[1:0];
    line_hit     = valid[req_idx] && (line_tag[req_idx] == req_tag);
    victim_dirty = valid[req_idx] && dirty[req_idx];
  end

  // Cache controller, cache arrays, memory and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= COMPARE;
      request_num      <= 4'd0;
      read_data_cache  <= 32'h0;
      hit_miss         <= 1'b0;
      read_write_cache <= 1'b0;
      miss_flag        <= 1'b0;
      valid            <= 4'h0;
      dirty            <= 4'h0;
      for (int l = 0; l < 4; l++) begin
        line_tag[l[1:0]] <= 4'h0;
        for (int w = 0; w < 4; w++) begin
          line_data[l[1:0]][w[1:0]] <= 32'h0;
        end
      end
      // Each word holds its own byte address after reset
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i[MEM_AW-1:0]] <= 32'(i) << 2;
      end
    end else begin
      case (state)
        COMPARE: begin
          if (line_hit) begin
            if (req_we) begin
              line_data[req_idx][req_word] <= req_wdata;
              dirty[req_idx]               <= 1'b1;
              read_data_cache              <= req_wdata;
            end else begin
              read_data_cache <= line_data[req_idx][req_word];
            end
            hit_miss         <= ~miss_flag;
            read_write_cache <= req_we;
            miss_flag        <= 1'b0;
            request_num      <= 4'(request_num + 4'd1);
            if (request_num == 4'(NUM_REQ - 1)) begin
              state <= DONE;
            end
          end else begin
            miss_flag <= 1'b1;
            state     <= victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          for (int w = 0; w < 4; w++) begin
            mem[MEM_AW'({line_tag[req_idx], req_idx, w[1:0]})] <=
              line_data[req_idx][w[1:0]];
          end
          state <= ALLOCATE;
        end
        ALLOCATE: begin
          for (int w = 0; w < 4; w++) begin
            line_data[req_idx][w[1:0]] <=
              mem[MEM_AW'({req_tag, req_idx, w[1:0]})];
          end
          valid[req_idx]    <= 1'b1;
          dirty[req_idx]    <= 1'b0;
          line_tag[req_idx] <= req_tag;
          state             <= COMPARE;
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= COMPARE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_top.sv
// tb_cache_top: drives reset at randomized points and checks every cycle of
// the request sequence against a request-level cache/memory model.
module tb_cache_top;

  localparam int NREQ = 8;

  logic        clock;
  logic        reset;
  logic [31:0] read_data_cache;
  logic        hit_miss;
  logic        read_write_cache;
  logic [3:0]  request_num;

  int total;
  int bad;

  // Expected per-request results: completion cycle after reset release
  int          exp_cyc  [NREQ];
  logic [31:0] exp_data [NREQ];
  logic        exp_hit  [NREQ];
  logic        exp_rw   [NREQ];

  cache_top #(.NUM_REQ(NREQ), .MEM_WORDS(256)) dut (
    .clock            (clock),
    .reset            (reset),
    .read_data_cache  (read_data_cache),
    .hit_miss         (hit_miss),
    .read_write_cache (read_write_cache),
    .request_num      (request_num)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Request-level model: walk the table, track lines and memory, derive
  // hit/miss, latency and returned data for each request.
  task automatic build_model();
    bit          t_we   [NREQ];
    int          t_addr [NREQ];
    logic [31:0] t_wd   [NREQ];
    logic [31:0] m_mem  [256];
    logic [31:0] c_data [4][4];
    int          c_tag  [4];
    bit          c_val  [4];
    bit          c_dirty[4];
    int          cyc;
    t_we = '{0, 0, 1, 0, 0, 0, 1, 0};
    t_addr = '{'h000, 'h004, 'h008, 'h008, 'h040, 'h008, 'h014, 'h014};
    t_wd = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h12345678, 32'h0};
    for (int i = 0; i < 256; i++) m_mem[i] = 32'(i * 4);
    for (int l = 0; l < 4; l++) begin
      c_val[l] = 0;
      c_dirty[l] = 0;
      c_tag[l] = 0;
    end
    cyc = 0;
    for (int r = 0; r < NREQ; r++) begin
      int blk, idx, tg, wd;
      blk = t_addr[r] / 16;
      idx = blk % 4;
      tg  = blk / 4;
      wd  = (t_addr[r] / 4) % 4;
      if (c_val[idx] && c_tag[idx] == tg) begin
        cyc += 1;
        exp_hit[r] = 1'b1;
      end else begin
        if (c_val[idx] && c_dirty[idx]) begin
          for (int w = 0; w < 4; w++) m_mem[(c_tag[idx] * 4 + idx) * 4 + w] = c_data[idx][w];
          cyc += 4;
        end else begin
          cyc += 3;
        end
        for (int w = 0; w < 4; w++) c_data[idx][w] = m_mem[blk * 4 + w];
        c_val[idx] = 1;
        c_dirty[idx] = 0;
        c_tag[idx] = tg;
        exp_hit[r] = 1'b0;
      end
      if (t_we[r]) begin
        c_data[idx][wd] = t_wd[r];
        c_dirty[idx] = 1;
      end
      exp_data[r] = c_data[idx][wd];
      exp_rw[r]   = t_we[r];
      exp_cyc[r]  = cyc;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    n = $urandom_range(1, 3);
    for (int k = 0; k < n; k++) begin
      tick();
      total++;
      if (request_num !== 4'd0 || read_data_cache !== 32'h0 ||
          hit_miss !== 1'b0 || read_write_cache !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: num=%0d data=%h hm=%b rw=%b required 0/0/0/0",
                 request_num, read_data_cache, hit_miss, read_write_cache);
      end
    end
    reset = 1'b0;
  endtask

  // Assumes reset was released right after the previous active edge
  task automatic test_sequence(input string tag);
    for (int k = 1; k <= 20; k++) begin
      int          done_n;
      logic [31:0] e_data;
      logic        e_hit, e_rw;
      tick();
      done_n = 0;
      for (int r = 0; r < NREQ; r++) if (exp_cyc[r] <= k) done_n++;
      e_data = (done_n == 0) ? 32'h0 : exp_data[done_n-1];
      e_hit  = (done_n == 0) ? 1'b0  : exp_hit[done_n-1];
      e_rw   = (done_n == 0) ? 1'b0  : exp_rw[done_n-1];
      total++;
      if (request_num !== 4'(done_n)) begin
        bad++;
        $display("FAIL %s_num cycle %0d: got %0d required %0d", tag, k, request_num, done_n);
      end
      total++;
      if (read_data_cache !== e_data || hit_miss !== e_hit || read_write_cache !== e_rw) begin
        bad++;
        $display("FAIL %s_out cycle %0d: got data=%h hm=%b rw=%b required data=%h hm=%b rw=%b",
                 tag, k, read_data_cache, hit_miss, read_write_cache, e_data, e_hit, e_rw);
      end
    end
  endtask

  task automatic test_done_hold();
    int n;
    n = $urandom_range(5, 40);
    for (int k = 0; k < n; k++) begin
      tick();
      total++;
      if (request_num !== 4'd8 || read_data_cache !== 32'h12345678 ||
          hit_miss !== 1'b1 || read_write_cache !== 1'b0) begin
        bad++;
        $display("FAIL done_hold: num=%0d data=%h hm=%b rw=%b required 8/12345678/1/0",
                 request_num, read_data_cache, hit_miss, read_write_cache);
      end
    end
  endtask

  // Request 4 misses on a dirty victim: after 7 cycles the FSM is in WRITEBACK
  task automatic test_reset_mid_writeback();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    total++;
    if (request_num !== 4'd4) begin
      bad++;
      $display("FAIL pre_writeback_num: got %0d required 4", request_num);
    end
    reset = 1'b1;
    tick();
    total++;
    if (request_num !== 4'd0 || read_data_cache !== 32'h0 ||
        hit_miss !== 1'b0 || read_write_cache !== 1'b0) begin
      bad++;
      $display("FAIL mid_writeback_reset: num=%0d data=%h hm=%b rw=%b required 0/0/0/0",
               request_num, read_data_cache, hit_miss, read_write_cache);
    end
    reset = 1'b0;
  endtask

  // Reset at a random point in the sequence, held a random number of cycles
  task automatic test_random_reset();
    int n;
    n = $urandom_range(0, 20);
    for (int k = 0; k < n; k++) tick();
    test_reset();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    build_model();
    test_reset();
    test_sequence("seq");
    test_done_hold();
    test_reset_mid_writeback();
    test_sequence("restart");
    for (int r = 0; r < 4; r++) begin
      test_random_reset();
      test_sequence("rand_restart");
    end
    test_done_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
